// File: rtl/bus_arbiter_mux.sv
// ============================================================================
// Module   : bus_arbiter_mux
// Purpose  : Arbitrated, registered bus multiplexer (fixed-priority or round-robin).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter_mux #(
  parameter int DATA_W  = 8,
  parameter int N_SRC   = 4,
  parameter int N_DST   = 4,
  parameter int RR_MODE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_SRC-1:0]        src_req,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_grant,
  input  logic [N_DST-1:0]        dst_load,
  output logic [DATA_W-1:0]       dst_data,
  output logic [N_DST-1:0]        dst_valid,
  output logic                    bus_busy,
  output logic                    err_orphan,
  input  logic                    err_clear
);

  localparam int IDX_W = $clog2(N_SRC);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t             state_q;
  logic [N_SRC-1:0]   grant_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [DATA_W-1:0]  data_q;
  logic [N_DST-1:0]   valid_q;
  logic               err_q;

  logic               req_any;
  logic [IDX_W-1:0]   search_base;
  logic [IDX_W:0]     search_off;
  logic [IDX_W-1:0]   win_idx;
  logic [N_SRC-1:0]   grant_d;
  logic [IDX_W-1:0]   ptr_d;
  logic [DATA_W-1:0]  data_d;

  // Search downward so the candidate closest to the base (lowest offset) wins.
  always_comb begin
    req_any     = |src_req;
    search_base = (RR_MODE != 0) ? ptr_q : '0;
    search_off  = '0;
    win_idx     = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      search_off = {1'b0, search_base} + (IDX_W + 1)'(k);
      if (search_off >= (IDX_W + 1)'(N_SRC)) begin
        search_off = search_off - (IDX_W + 1)'(N_SRC);
      end
      if (src_req[search_off[IDX_W-1:0]]) begin
        win_idx = search_off[IDX_W-1:0];
      end
    end
    grant_d          = '0;
    grant_d[win_idx] = 1'b1;
    ptr_d            = (win_idx == IDX_W'(N_SRC - 1)) ? '0 : win_idx + 1'b1;
  end

  always_comb begin
    data_d = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q[i]) begin
        data_d = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((|dst_load) && (grant_q == '0)) begin
        err_q <= 1'b1;
      end else if (err_clear) begin
        err_q <= 1'b0;
      end

      valid_q <= '0;
      if (state_q == S_GRANT) begin
        data_q  <= data_d;
        valid_q <= dst_load;
      end

      // Re-arbitrate on every edge so back-to-back beats need no idle cycle.
      if (req_any) begin
        grant_q <= grant_d;
        state_q <= S_GRANT;
        if (RR_MODE != 0) begin
          ptr_q <= ptr_d;
        end
      end else begin
        grant_q <= '0;
        state_q <= S_IDLE;
      end
    end
  end

  assign src_grant  = grant_q;
  assign dst_data   = data_q;
  assign dst_valid  = valid_q;
  assign bus_busy   = |grant_q;
  assign err_orphan = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_mux.sv
// ============================================================================
// Module   : tb_bus_arbiter_mux
// Purpose  : Self-checking bench driving a fixed-priority and a round-robin instance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter_mux;

  localparam int DW = 8;
  localparam int NS = 4;
  localparam int ND = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NS-1:0]    src_req;
  logic [NS*DW-1:0] src_data;
  logic [ND-1:0]    dst_load;
  logic             err_clear;

  logic [NS-1:0] g0, g1;
  logic [DW-1:0] d0, d1;
  logic [ND-1:0] v0, v1;
  logic          b0, b1, e0, e1;

  always #5 clk = ~clk;

  bus_arbiter_mux #(.DATA_W(DW), .N_SRC(NS), .N_DST(ND), .RR_MODE(0)) dut_fp (
    .clk(clk), .reset(reset), .src_req(src_req), .src_data(src_data),
    .src_grant(g0), .dst_load(dst_load), .dst_data(d0), .dst_valid(v0),
    .bus_busy(b0), .err_orphan(e0), .err_clear(err_clear)
  );

  bus_arbiter_mux #(.DATA_W(DW), .N_SRC(NS), .N_DST(ND), .RR_MODE(1)) dut_rr (
    .clk(clk), .reset(reset), .src_req(src_req), .src_data(src_data),
    .src_grant(g1), .dst_load(dst_load), .dst_data(d1), .dst_valid(v1),
    .bus_busy(b1), .err_orphan(e1), .err_clear(err_clear)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = fixed priority, index 1 = round-robin.
  int            m_gnt   [2];
  int            m_ptr   [2];
  logic [DW-1:0] m_data  [2];
  logic [ND-1:0] m_valid [2];
  bit            m_err   [2];
  int            m_new;
  bit            started = 1'b0;

  function automatic int pick(input int mode, input int ptr, input logic [NS-1:0] req);
    for (int k = 0; k < NS; k++) begin
      int i;
      i = (mode != 0) ? (ptr + k) % NS : k;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        m_gnt[m] = -1; m_ptr[m] = 0; m_data[m] = '0; m_valid[m] = '0; m_err[m] = 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (dst_load != '0 && m_gnt[m] < 0) m_err[m] = 1'b1;
        else if (err_clear) m_err[m] = 1'b0;
        if (m_gnt[m] >= 0) begin
          m_data[m]  = src_data[m_gnt[m]*DW +: DW];
          m_valid[m] = dst_load;
        end else begin
          m_valid[m] = '0;
        end
        m_new = pick(m, m_ptr[m], src_req);
        if (m_new >= 0 && m == 1) m_ptr[m] = (m_new + 1) % NS;
        m_gnt[m] = m_new;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int m = 0; m < 2; m++) begin
        logic [NS-1:0] eg;
        string tag;
        tag = (m == 0) ? "fp" : "rr";
        eg = '0;
        if (m_gnt[m] >= 0) eg[m_gnt[m]] = 1'b1;
        check($sformatf("grant_%s", tag), (m == 0) ? g0 : g1, eg);
        check($sformatf("busy_%s", tag),  (m == 0) ? b0 : b1, (eg != '0));
        check($sformatf("data_%s", tag),  (m == 0) ? d0 : d1, m_data[m]);
        check($sformatf("valid_%s", tag), (m == 0) ? v0 : v1, m_valid[m]);
        check($sformatf("err_%s", tag),   (m == 0) ? e0 : e1, m_err[m]);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    src_req = '0; src_data = '0; dst_load = '0; err_clear = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    started = 1'b1;

    // Reset held with random inputs
    for (int c = 0; c < 4; c++) begin
      src_req = NS'($urandom); src_data = $urandom; dst_load = ND'($urandom); err_clear = 1'($urandom);
      tick();
      check("rst_grant", g0 | g1, 0);
      check("rst_data", d0 | d1, 0);
      check("rst_valid_err", {v0, v1, e0, e1, b0, b1}, 0);
    end

    src_req = '0; dst_load = '0; err_clear = 1'b0;
    src_data = 32'h44_A5_22_11;
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("idle_grant", {g0, g1, b0, b1}, 0);
    end

    // Single transfer from source 2
    src_req = 4'b0100;
    tick();
    check("single_grant_fp", g0, 4'b0100);
    check("single_grant_rr", g1, 4'b0100);
    src_req = '0; dst_load = 4'b0011;
    tick();
    check("single_data", d0, 8'hA5);
    check("single_valid", v0, 4'b0011);
    check("single_grant_done", g0, 0);
    dst_load = '0;
    tick();
    check("single_valid_pulse", v0, 0);
    check("single_data_hold", d0, 8'hA5);

    // Fixed priority, held requests
    src_req = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("fp_grant", g0, 4'b0010);
      check("fp_busy", b0, 1);
    end
    src_req = '0;
    tick(2);
    check("fp_data", d0, 8'h22);

    // Round-robin rotation, then drop to 1001 after grant 0010
    src_req = 4'b1111;
    tick(); check("rr_g0", g1, 4'b0001);
    tick(); check("rr_g1", g1, 4'b0010);
    tick(); check("rr_g2", g1, 4'b0100);
    tick(); check("rr_g3", g1, 4'b1000);
    tick(); check("rr_g4", g1, 4'b0001);
    tick(); check("rr_g5", g1, 4'b0010);
    src_req = 4'b1001;
    tick(); check("rr_g6", g1, 4'b1000);
    src_req = '0;
    tick(2);

    // Orphan load
    dst_load = 4'b0001;
    tick(); check("orphan_set", {e0, e1}, 2'b11);
    dst_load = '0;
    tick(); check("orphan_sticky", {e0, e1}, 2'b11);
    err_clear = 1'b1;
    tick(); check("orphan_clear", {e0, e1}, 2'b00);
    dst_load = 4'b0001;
    tick(); check("orphan_set_wins", {e0, e1}, 2'b11);
    dst_load = '0;
    tick(); check("orphan_cleared_again", {e0, e1}, 2'b00);
    err_clear = 1'b0;

    // Reset during grant cycle for source 1
    src_data[1*DW +: DW] = 8'h5A;
    src_req = 4'b0010;
    tick();
    check("mid_grant", g0, 4'b0010);
    src_req = '0; dst_load = 4'b0001;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_grant", {g0, g1}, 0);
    check("mid_rst_valid", {v0, v1}, 0);
    check("mid_rst_data", {d0, d1}, 0);
    dst_load = '0;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post_rst_grant", {g0, g1}, 0);
      check("post_rst_data", {d0, d1, v0, v1}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_arbiter_mux.md
Name: bus_arbiter_mux

Overview:
- Parametrised successor to the shared tristate data bus. Replaces tristate drivers with an arbitrated, registered multiplexer.
- N_SRC sources request the bus and one grant is issued per beat.
- The granted source's word is captured into a bus register and delivered to every sink whose load strobe is set in that beat.
- Sits between the memory, register bank, opcode register and future peripherals. Adds fixed-priority or round-robin arbitration, back-to-back beats and error flagging.

Parameters:
- DATA_W, 8, bus word width in bits.
- N_SRC, 4, number of requesting sources (2..16).
- N_DST, 4, number of load sinks (1..16).
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- src_req  input  N_SRC  per-source bus request, level.
- src_data  input  N_SRC*DATA_W  source words; source i occupies bits [i*DATA_W +: DATA_W].
- src_grant  output  N_SRC  registered one-hot grant; high for exactly one beat.
- dst_load  input  N_DST  sink load strobes, sampled during the grant cycle.
- dst_data  output  DATA_W  bus register contents.
- dst_valid  output  N_DST  one-cycle pulse per sink that loaded.
- bus_busy  output  1  high while src_grant is non-zero.
- err_orphan  output  1  sticky flag: a dst_load bit was high in a cycle with no grant.
- err_clear  input  1  synchronous clear of err_orphan.

Behaviour:
- Reset (reset=0, async): src_grant=0, dst_data=0, dst_valid=0, bus_busy=0, err_orphan=0, rr pointer=0, state=IDLE.
- States: IDLE and GRANT.
- IDLE:
  - If any src_req bit is set at the edge, register the winner into src_grant and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (one cycle per beat):
  - At the closing edge, dst_data <= src_data of the granted source, and dst_valid <= dst_load sampled this cycle.
  - In the same edge, arbitrate again on current src_req. If any bit is set, issue a new one-hot grant and stay in GRANT (back-to-back, no bubble). Otherwise clear src_grant and go to IDLE.
- Latency: req seen at edge E1 -> src_grant high in cycle E1..E2 -> dst_data/dst_valid valid in cycle E2..E3. Total 2 cycles from req to data.
- The source must hold src_data stable for its whole grant cycle.
- A grant is a commitment: the beat completes even if src_req drops during the grant cycle.
- To avoid a second grant, a source deasserts req in its grant cycle.
- Fixed priority (RR_MODE=0):
  - The lowest set index wins.
  - A source holding req continuously is re-granted every beat. Starvation of higher indices is permitted.
- Round-robin (RR_MODE=1):
  - Search starts at rr pointer and wraps modulo N_SRC. The first set bit wins.
  - On each grant, pointer <= winner+1, wrapping N_SRC-1 -> 0.
  - The pointer does not change in beats with no grant.
- dst_valid:
  - Pulses for exactly one cycle, then returns to 0 unless the next beat loads again.
  - With dst_load=0 in the grant cycle, the beat completes, dst_data updates and dst_valid stays 0.
- dst_data holds its last value between beats.
- err_orphan:
  - Set at the edge when dst_load != 0 and src_grant == 0.
  - err_clear=1 clears it. If set and clear coincide, set wins.
- Reset mid-beat aborts the beat immediately:
  - No dst_valid pulse.
  - dst_data=0.
  - The requester must re-request.
- src_grant is always one-hot or zero; no two sources are ever granted.

Test Plan:
- Reset/idle:
  - Hold reset=0 with random inputs -> all outputs 0.
  - Release with src_req=0 for 5 cycles -> src_grant=0, bus_busy=0.
- Single transfer:
  - src_req=4'b0100, src_data[2]=8'hA5, dst_load=4'b0011 in grant cycle.
  - -> src_grant=4'b0100 one cycle after req.
  - -> next cycle dst_data=8'hA5, dst_valid=4'b0011 for one cycle.
- Fixed priority (RR_MODE=0):
  - src_req=4'b1010 held for 3 beats -> src_grant=4'b0010 every beat, back-to-back.
  - bus_busy stays high, with no idle cycle.
- Round-robin (RR_MODE=1):
  - src_req=4'b1111 held -> grants cycle 0001,0010,0100,1000,0001.
  - Drop to 4'b1001 after grant 0010 -> next grant 1000.
- Orphan load:
  - dst_load=4'b0001 while idle -> err_orphan=1 next cycle and stays set.
  - err_clear=1 -> 0 next cycle.
  - err_clear together with a new orphan -> remains 1.
- Reset mid-beat:
  - Assert reset=0 during the grant cycle for src 1 -> src_grant=0, dst_valid=0, dst_data=0 immediately.
  - After release with src_req=0 -> no transfer occurs.
